mul_sequencer: RTL and testbench

Multi-cycle controller for the `mul`, `mulh` and `mulhu` operations, sitting beside the ALU in the EX stage of the 3-stage RV32 pipeline. When the decoder issues one of these aluops, the block latches the operands and runs a 32-step radix-2 shift-add multiply. It holds the fetch stage stalled until the product is ready, then pulses `done` with the selected 32-bit result.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/mul_shift_add.sv | 65 ++++++
 rtl/mul_sequencer.sv | 117 +++++++++++
 tb/tb_mul_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply sequencer: ALU opcodes
// for the multiply class, the sequencer state encoding and the step count.
package cpu_pkg;

   localparam logic [3:0] ALU_MUL   = 4'b0101;
   localparam logic [3:0] ALU_MULH  = 4'b0110;
   localparam logic [3:0] ALU_MULHU = 4'b0111;

   localparam int MUL_STEPS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mul_state_t;

   // Which half of the product is returned once the sequence completes.
   typedef enum logic [1:0] {
      KIND_MUL   = 2'd0,
      KIND_MULH  = 2'd1,
      KIND_MULHU = 2'd2
   } mul_kind_t;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
   endfunction

   function automatic mul_kind_t decode_kind(input logic [3:0] op);
      mul_kind_t k;
      case (op)
         ALU_MULH:  k = KIND_MULH;
         ALU_MULHU: k = KIND_MULHU;
         default:   k = KIND_MUL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: a 2W-bit accumulator, a multiplicand that shifts
// left and a multiplier that shifts right. One partial product per step strobe;
// the fix strobe applies the sign correction in place.
module mul_shift_add #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic           fix,
   input  logic [W-1:0]   mcand_in,
   input  logic [W-1:0]   mplier_in,
   input  logic           neg_in,
   output logic [2*W-1:0] product_fixed
);

   logic [2*W-1:0] acc_q, acc_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic           neg_q, neg_d;

   // Sign-corrected view of the accumulator; stays valid after fix because
   // the fix strobe commits it and clears the pending negation.
   assign product_fixed = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;

   // Next-state for the datapath registers, selected by the strobes.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      if (load) begin
         acc_d    = '0;
         mcand_d  = {{W{1'b0}}, mcand_in};
         mplier_d = mplier_in;
         neg_d    = neg_in;
      end else if (step) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = {mcand_q[2*W-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[W-1:1]};
      end else if (fix) begin
         acc_d = product_fixed;
         neg_d = 1'b0;
      end
   end

   // Datapath registers; an in-flight product is discarded on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle controller for mul/mulh/mulhu in EX. Accepts an op from IDLE,
// runs 32 shift-add steps, sign-corrects, then pulses done with the result.
// Fixed latency of 34 cycles from accept to done, regardless of operands.
module mul_sequencer
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      aluop,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(MUL_STEPS);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

   mul_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   mul_kind_t        kind_q, kind_d;
   logic [XLEN-1:0]  result_q, result_d;

   logic             accept;
   logic             is_mulh;
   logic [XLEN-1:0]  a_mag, b_mag;
   logic             neg;
   logic             load, step, fix;
   logic [2*XLEN-1:0] product_fixed;

   // Accept is gated by rst so stall drops the instant reset is asserted.
   assign accept  = start && !rst && (state_q == IDLE) && is_mul_op(aluop);
   assign is_mulh = (aluop == ALU_MULH);

   // mulh works on magnitudes and negates afterwards; |0x80000000| wraps to
   // itself, which is still the correct unsigned magnitude.
   assign a_mag = (is_mulh && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
   assign b_mag = (is_mulh && b[XLEN-1]) ? (~b + XLEN'(1)) : b;
   assign neg   = is_mulh && (a[XLEN-1] ^ b[XLEN-1]);

   mul_shift_add #(.W(XLEN)) u_dp (
      .clk           (clk),
      .rst           (rst),
      .load          (load),
      .step          (step),
      .fix           (fix),
      .mcand_in      (a_mag),
      .mplier_in     (b_mag),
      .neg_in        (neg),
      .product_fixed (product_fixed)
   );

   // FSM next-state, step counter, datapath strobes and result capture.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      kind_d   = kind_q;
      result_d = result_q;
      load     = 1'b0;
      step     = 1'b0;
      fix      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               count_d = '0;
               kind_d  = decode_kind(aluop);
               load    = 1'b1;
            end
         end
         RUN: begin
            step    = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_STEP) begin
               state_d = FIX;
            end
         end
         FIX: begin
            fix      = 1'b1;
            result_d = (kind_q == KIND_MUL) ? product_fixed[XLEN-1:0]
                                            : product_fixed[2*XLEN-1:XLEN];
            state_d  = DONE;
         end
         DONE: begin
            // start is deliberately ignored here; the next op waits for IDLE
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         kind_q   <= KIND_MUL;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         kind_q   <= kind_d;
         result_q <= result_d;
      end
   end

   assign stall  = accept || (state_q == RUN) || (state_q == FIX);
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: the driver pushes expected results with
// their accept cycle; a monitor pops on every done pulse and checks value,
// latency and the length of the preceding stall window.
module tb_mul_sequencer;

   localparam int XLEN    = 32;
   localparam int LATENCY = 34;

   logic            clk;
   logic            rst;
   logic            start;
   logic [3:0]      aluop;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   typedef struct {
      logic [31:0] exp;
      int          acc_cyc;
      string       name;
   } sb_item_t;

   sb_item_t sb_q[$];

   int n_pass;
   int n_total;
   int cyc;
   int done_cnt;
   int stall_run;

   mul_sequencer #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .aluop  (aluop),
      .a      (a),
      .b      (b),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   initial begin
      sb_item_t it;
      done_cnt  = 0;
      stall_run = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_run = 0;
         end else if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               it = sb_q.pop_front();
               $display("txn %s: result=0x%08h latency=%0d stall_cycles=%0d",
                        it.name, result, cyc - it.acc_cyc, stall_run);
               chk({it.name, "_result"}, result, it.exp);
               chk({it.name, "_latency"}, 32'(cyc - it.acc_cyc), 32'(LATENCY));
               chk({it.name, "_stall_len"}, 32'(stall_run), 32'(LATENCY));
               chk({it.name, "_stall_at_done"}, {31'd0, stall}, 32'd0);
            end
            stall_run = 0;
         end else if (stall) begin
            stall_run++;
         end
      end
   end

   // Drive one op for a single cycle and record its expectation.
   task automatic issue(input string name, input logic [3:0] op,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp);
      sb_item_t it;
      @(posedge clk); #1;
      start = 1'b1; aluop = op; a = av; b = bv;
      it.exp = exp; it.acc_cyc = cyc; it.name = name;
      sb_q.push_back(it);
      #1 chk({name, "_stall_cycle0"}, {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Bounded wait for the scoreboard to drain.
   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         chk({name, "_timeout"}, 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int c0;
      int d0;
      sb_item_t it;
      n_pass = 0; n_total = 0;
      rst = 1'b1; start = 1'b0; aluop = 4'd0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall",  {31'd0, stall}, 32'd0);
      chk("reset_busy",   {31'd0, busy},  32'd0);
      chk("reset_done",   {31'd0, done},  32'd0);
      chk("reset_result", result,         32'd0);
      rst = 1'b0;

      issue("mul_7x6",      4'b0101, 32'd7,        32'd6,        32'd42);
      wait_drain("mul_7x6");
      issue("mulh_m2x3",    4'b0110, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF);
      wait_drain("mulh_m2x3");
      issue("mulh_min_sq",  4'b0110, 32'h80000000, 32'h80000000, 32'h40000000);
      wait_drain("mulh_min_sq");
      issue("mulhu_ff_sq",  4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      wait_drain("mulhu_ff_sq");
      issue("mul_ff_sq",    4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      wait_drain("mul_ff_sq");

      // Non-multiply aluop with start held is ignored.
      @(posedge clk); #1;
      start = 1'b1; aluop = 4'b0011; a = 32'd9; b = 32'd9;
      repeat (3) @(posedge clk);
      #2;
      chk("ignored_op_stall", {31'd0, stall}, 32'd0);
      chk("ignored_op_busy",  {31'd0, busy},  32'd0);
      start = 1'b0;
      issue("mul_zero",     4'b0101, 32'd0,        32'd123,      32'd0);
      wait_drain("mul_zero");

      // Back-to-back with start held through DONE.
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; aluop = 4'b0101; a = 32'd3; b = 32'd5;
      c0 = cyc;
      it.exp = 32'd15; it.acc_cyc = c0; it.name = "b2b_3x5";
      sb_q.push_back(it);
      while (cyc < c0 + LATENCY) @(posedge clk);
      #1;
      a = 32'd4; b = 32'd4;
      it.exp = 32'd16; it.acc_cyc = c0 + LATENCY + 1; it.name = "b2b_4x4";
      sb_q.push_back(it);
      while (cyc < c0 + LATENCY + 2) @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain("b2b");
      chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

      // Asynchronous reset in the middle of RUN discards the op.
      @(posedge clk); #1;
      start = 1'b1; aluop = 4'b0101; a = 32'd9; b = 32'd9;
      c0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < c0 + 10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_stall",  {31'd0, stall}, 32'd0);
      chk("rst_mid_busy",   {31'd0, busy},  32'd0);
      chk("rst_mid_done",   {31'd0, done},  32'd0);
      chk("rst_mid_result", result,         32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      issue("mul_after_rst", 4'b0101, 32'd2,        32'd2,        32'd4);
      wait_drain("mul_after_rst");

      repeat (5) @(posedge clk);
      chk("total_done_pulses", 32'(done_cnt), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
